// File: rtl/blit_wbuf_if.sv
// blit_wbuf_if: write-phrase and memory-request signals between the blitter data path, the write-back buffer and memory
interface blit_wbuf_if #(parameter int AW = 21);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [7:0]    wr_dbinh_n;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_data;
  logic [7:0]    mem_be;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_dbinh_n, mem_ack,
    input  wr_ready, mem_req, mem_addr, mem_data, mem_be
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_dbinh_n, mem_ack,
    output wr_ready, mem_req, mem_addr, mem_data, mem_be
  );
endinterface

// File: rtl/blit_wbuf.sv
// blit_wbuf: blitter write-back queue draining phrases to memory over req/ack; BLIT_WBUF_MERGE_EN enables tail merging
module blit_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 21
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  blit_wbuf_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = AW + 72;
  logic [EW-1:0] q [DEPTH];
  logic [PW-1:0] head, tail, head_n, tail_m1;
  logic [LW-1:0] level_n;
  logic [EW-1:0] head_ent, head_ent_n, wr_ent, merged;
  logic [63:0]   m_data;
  logic          can_merge, xfer, live, alloc, mrg, pop;
  assign tail_m1 = tail - PW'(1);
`ifdef BLIT_WBUF_MERGE_EN
  // With two or more entries the tail is never the one on the memory bus, so it may still be modified
  assign can_merge = (level >= LW'(2)) && (bus.wr_addr == q[tail_m1][EW-1:72]);
`else
  assign can_merge = 1'b0;
`endif
  assign bus.wr_ready = (level < LW'(DEPTH)) | can_merge;
  assign xfer    = bus.wr_valid & bus.wr_ready;
  assign live    = |bus.wr_dbinh_n;
  assign alloc   = xfer & live & ~can_merge;
  assign mrg     = xfer & live & can_merge;
  assign pop     = bus.mem_req & bus.mem_ack;
  assign head_n  = head + PW'(pop);
  assign level_n = level + LW'(alloc) - LW'(pop);
  assign wr_ent  = {bus.wr_addr, bus.wr_data, bus.wr_dbinh_n};
  // Tail entry with the enabled bytes of the incoming phrase overlaid
  always_comb begin
    m_data = q[tail_m1][71:8];
    for (int i = 0; i < 8; i++)
      if (bus.wr_dbinh_n[i]) m_data[8*i +: 8] = bus.wr_data[8*i +: 8];
  end
  assign merged = {q[tail_m1][EW-1:72], m_data, q[tail_m1][7:0] | bus.wr_dbinh_n};
  // Entry that will sit at the head after this edge, forwarding any same-cycle write into that slot
  always_comb begin
    head_ent_n = (level_n == '0) ? '0 :
                 (alloc && head_n == tail) ? wr_ent :
                 (mrg && head_n == tail_m1) ? merged : q[head_n];
  end
  // Pointers, occupancy and the registered head presentation
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      head_ent <= '0;
    end else begin
      head     <= head_n;
      tail     <= tail + PW'(alloc);
      level    <= level_n;
      head_ent <= head_ent_n;
    end
  end
  // Entry storage; contents are only meaningful between head and tail so it needs no reset
  always_ff @(posedge sys_clk) begin
    if (alloc) q[tail] <= wr_ent;
    if (mrg) q[tail_m1] <= merged;
  end
  assign bus.mem_req = (level != '0);
  assign {bus.mem_addr, bus.mem_data, bus.mem_be} = head_ent;
  assign idle = (level == '0) & ~bus.wr_valid;
endmodule
